// File: rtl/spu_ldst_pkg.sv
// Shared constants and error-cause encoding for the SPU load/store packet queue.
package spu_ldst_pkg;

    localparam int SPU_PCKT_W  = 123;
    localparam int SPU_CPX_W   = 135;
    localparam int CPX_VLD_BIT = SPU_CPX_W - 1;

    // Bit positions in the per-cycle error-cause vector.
    typedef enum logic [0:0] {
        ACK_NO_VLD   = 1'b0,
        RET_NO_OUTST = 1'b1
    } spu_ldst_err_e;

endpackage

// File: rtl/spu_ldst_fifo.sv
// Generic DEPTH x W synchronous FIFO; head shows the oldest entry, zero when empty.
module spu_ldst_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 123
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   occ_q, occ_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          push_ok, pop_ok;

    always_comb begin
        full    = (occ_q == (PW+1)'(DEPTH));
        empty   = (occ_q == '0);
        head    = empty ? '0 : mem_q[rd_ptr_q];
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Pointers wrap for free because DEPTH is a power of two.
        if (push_ok && !pop_ok) begin
            occ_d = occ_q + (PW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            occ_d = occ_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/spu_ldst_pckt_q.sv
// SPU load/store packet queue: buffers MA packets toward the LSU repeater and
// throttles issue against CPX returns with an outstanding-request credit count.
module spu_ldst_pckt_q
    import spu_ldst_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int MAX_OUTST = 4,
    parameter int PCKT_W    = SPU_PCKT_W,
    parameter int CPX_W     = SPU_CPX_W
) (
    input  logic                             rclk,
    input  logic                             rst,
    input  logic                             spu_ldst_pckt_vld,
    input  logic [PCKT_W-1:0]                spu_ldst_pckt,
    output logic                             spu_ldst_pckt_rdy,
    output logic [PCKT_W-1:0]                spu_lsurpt_ldst_pckt_in,
    output logic                             spu_ldst_pckt_out_vld,
    input  logic                             lsu_spu_ldst_ack,
    input  logic [CPX_W-1:0]                 spu_lsurpt_cpx_data_out,
    output logic [CPX_W-1:0]                 spu_cpx_data_q,
    output logic [$clog2(MAX_OUTST+1)-1:0]   spu_ldst_outst_cnt,
    output logic                             spu_ldst_idle,
    output logic                             spu_ldst_err
);
    localparam int                CNT_W   = $clog2(MAX_OUTST+1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTST);

    logic             fifo_full, fifo_empty, push, pop, ret_vld, ret_ok;
    logic [CNT_W-1:0] outst_cnt_q, outst_cnt_d;
    logic             err_q, err_d;
    logic [CPX_W-1:0] cpx_q, cpx_d;
    logic [1:0]       err_cause;

    spu_ldst_fifo #(
        .DEPTH (DEPTH),
        .W     (PCKT_W)
    ) u_fifo (
        .clk   (rclk),
        .rst   (rst),
        .push  (push),
        .din   (spu_ldst_pckt),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (spu_lsurpt_ldst_pckt_in)
    );

    always_comb begin
        spu_ldst_pckt_rdy     = !fifo_full;
        spu_ldst_pckt_out_vld = !fifo_empty && (outst_cnt_q < MAX_CNT);
        push    = spu_ldst_pckt_vld && !fifo_full;
        pop     = lsu_spu_ldst_ack && spu_ldst_pckt_out_vld;
        ret_vld = spu_lsurpt_cpx_data_out[CPX_W-1];
        ret_ok  = ret_vld && (outst_cnt_q != '0);

        err_cause               = '0;
        err_cause[ACK_NO_VLD]   = lsu_spu_ldst_ack && !spu_ldst_pckt_out_vld;
        err_cause[RET_NO_OUTST] = ret_vld && (outst_cnt_q == '0);
        err_d = err_q || (|err_cause);

        // An issue and a return in the same cycle cancel out.
        outst_cnt_d = outst_cnt_q;
        if (pop && !ret_ok) begin
            outst_cnt_d = outst_cnt_q + CNT_W'(1);
        end else if (ret_ok && !pop) begin
            outst_cnt_d = outst_cnt_q - CNT_W'(1);
        end

        cpx_d = spu_lsurpt_cpx_data_out;

        spu_cpx_data_q     = cpx_q;
        spu_ldst_outst_cnt = outst_cnt_q;
        spu_ldst_err       = err_q;
        spu_ldst_idle      = fifo_empty && (outst_cnt_q == '0);
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            outst_cnt_q <= '0;
            err_q       <= 1'b0;
            cpx_q       <= '0;
        end else begin
            outst_cnt_q <= outst_cnt_d;
            err_q       <= err_d;
            cpx_q       <= cpx_d;
        end
    end

    a_outst_bound: assert property (@(posedge rclk) disable iff (rst) outst_cnt_q <= MAX_CNT);

endmodule
